autoplay_seq: RTL and testbench
===============================

AUTOPLAY_SEQ -- requirements
Module: autoplay_seq

Interface
REQ-001 Parameter COIN_WAIT, 120, frames spent in WAIT_COIN before a coin pulse.
REQ-002 Parameter PULSE_LEN, 6, frames each coin/start pulse is held active.
REQ-003 Parameter START_WAIT, 60, frames spent in WAIT_START before the start pulse.
REQ-004 Parameter THROW_PERIOD, 30, frames between throw-pulse starts in PLAY.
REQ-005 Parameter THROW_LEN, 3, frames each throw pulse is held active; SHALL be < THROW_PERIOD.
REQ-006 Parameter PLAY_LEN, 1800, frames spent in PLAY before returning to WAIT_COIN.
REQ-007 Parameter HOLDOFF, 600, frames autoplay stays idle after the last user activity.
REQ-008 clk6m  in  1  pixel/game clock; all logic is on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 enable  in  1  autoplay enable (board switch), level, synchronous to clk6m.
REQ-011 vsync_i  in  1  game vertical sync, asynchronous, active-high.
REQ-012 user_act  in  1  OR of the active-high user coin/start/throw buttons, asynchronous.
REQ-013 auto_coin_n  out  1  active-low coin request.
REQ-014 auto_start_n  out  1  active-low start request.
REQ-015 auto_throw_n  out  1  active-low throw request.
REQ-016 active  out  1  high in any state other than IDLE.
REQ-017 state_o  out  3  current state encoding, for LED/debug.

Function
REQ-018 vsync_i and user_act SHALL each pass through a 2-flop synchroniser; frame_tick SHALL be a one-cycle pulse on the synchronised vsync rising edge (3 clocks after the vsync_i rise).
REQ-019 States: IDLE=0, WAIT_COIN=1, COIN=2, WAIT_START=3, START=4, PLAY=5; codes 6 and 7 SHALL go to IDLE.
REQ-020 A 16-bit frame counter SHALL clear on every state change and increment on frame_tick; a timed state SHALL exit on the frame_tick that makes its count equal its parameter, giving exactly N ticks in the state.
REQ-021 A 16-bit holdoff counter SHALL load HOLDOFF on synchronised user_act and decrement on frame_tick down to 0.
REQ-022 IDLE->WAIT_COIN when enable=1 and holdoff=0.
REQ-023 WAIT_COIN->COIN after COIN_WAIT frames; COIN->WAIT_START after PULSE_LEN frames; WAIT_START->START after START_WAIT frames; START->PLAY after PULSE_LEN frames; PLAY->WAIT_COIN after PLAY_LEN frames.
REQ-024 From any state, enable=0 or synchronised user_act=1 SHALL force IDLE on the next edge, taking priority over every timed transition and over a coincident frame_tick.
REQ-025 In PLAY, auto_throw_n SHALL be 0 while (frame count mod THROW_PERIOD) < THROW_LEN, so a throw pulse starts on PLAY entry.
REQ-026 auto_coin_n=0 only in COIN, auto_start_n=0 only in START; all outputs SHALL be registered and change on the same edge as the state register.
REQ-027 Every auto_*_n output SHALL be 1 in the cycle after IDLE is forced, including when the abort occurs mid-pulse.
REQ-028 Counters SHALL saturate rather than wrap; parameters SHALL be 1..65535, and 0 is unsupported.

Reset
REQ-029 On reset: state=IDLE, counters=0, synchronisers=0, auto_*_n=1, active=0, state_o=0.
REQ-030 Reset asserted mid-pulse SHALL return every auto_*_n output to 1 on the same edge.

Structure
REQ-031 State encodings and the output-default constant SHALL live in the shared package ff_pkg.
REQ-032 A single sub-module sync_edge SHALL provide the 2-flop synchroniser and rising-edge pulse, instantiated for vsync_i and user_act.

Verification (params: COIN_WAIT=2, PULSE_LEN=2, START_WAIT=2, THROW_PERIOD=4, THROW_LEN=1, PLAY_LEN=8, HOLDOFF=3)
REQ-033 enable=1, 20 vsync pulses -> auto_coin_n low for exactly ticks 3-4, auto_start_n low for exactly ticks 7-8, auto_throw_n low on ticks 9 and 13, WAIT_COIN re-entered at tick 17.
REQ-034 user_act pulse during COIN -> auto_coin_n=1 and state_o=0 within 3 clocks; WAIT_COIN not re-entered until 3 further frame_ticks.
REQ-035 enable dropped during PLAY with throw active -> auto_throw_n=1 on the next edge; state_o=0.
REQ-036 Reset asserted in START -> auto_start_n=1 on the same edge; all outputs match REQ-029.
REQ-037 user_act and frame_tick in the same cycle as a WAIT_START exit -> IDLE wins; auto_start_n stays 1.
REQ-038 Force state=7 via the bench -> IDLE on the next edge with all auto_*_n=1.

Source files
------------

// File: rtl/ff_pkg.sv
// Shared state encodings, output bundle and counter helper for the autoplay sequencer.
package ff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_COIN  = 3'd1,
    ST_COIN       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_START      = 3'd4,
    ST_PLAY       = 3'd5
  } state_t;

  typedef struct packed {
    logic coin_n;
    logic start_n;
    logic throw_n;
    logic active;
  } auto_out_t;

  localparam auto_out_t OUT_DEFAULT = '{coin_n: 1'b1, start_n: 1'b1, throw_n: 1'b1, active: 1'b0};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser; EDGE=1 gives a one-cycle rising-edge pulse 3 clocks after d_i rises,
// EDGE=0 gives the synchronised level 2 clocks after d_i changes. No backpressure.
module sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic out_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign out_o = EDGE ? rise_q : sync_q;

endmodule

// File: rtl/autoplay_seq.sv
// Attract-mode autoplay: inserts a coin, presses start and throws periodically, yielding to any user.
// Outputs registered alongside the state; user activity or enable=0 aborts to IDLE on the next edge.
module autoplay_seq
  import ff_pkg::*;
#(
  parameter int unsigned COIN_WAIT    = 120,
  parameter int unsigned PULSE_LEN    = 6,
  parameter int unsigned START_WAIT   = 60,
  parameter int unsigned THROW_PERIOD = 30,
  parameter int unsigned THROW_LEN    = 3,
  parameter int unsigned PLAY_LEN     = 1800,
  parameter int unsigned HOLDOFF      = 600
) (
  input  logic       clk6m,
  input  logic       reset,
  input  logic       enable,
  input  logic       vsync_i,
  input  logic       user_act,
  output logic       auto_coin_n,
  output logic       auto_start_n,
  output logic       auto_throw_n,
  output logic       active,
  output logic [2:0] state_o
);

  localparam logic [15:0] COIN_WAIT_W    = 16'(COIN_WAIT);
  localparam logic [15:0] PULSE_LEN_W    = 16'(PULSE_LEN);
  localparam logic [15:0] START_WAIT_W   = 16'(START_WAIT);
  localparam logic [15:0] THROW_PERIOD_W = 16'(THROW_PERIOD);
  localparam logic [15:0] THROW_LEN_W    = 16'(THROW_LEN);
  localparam logic [15:0] PLAY_LEN_W     = 16'(PLAY_LEN);
  localparam logic [15:0] HOLDOFF_W      = 16'(HOLDOFF);

  logic      frame_tick;
  logic      user_sync;

  state_t    state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ph_q, ph_d;
  logic [15:0] hold_q, hold_d;
  auto_out_t out_q, out_d;

  logic [15:0] cnt_inc;
  logic [15:0] lim;
  logic        timed_out;

  sync_edge #(.EDGE(1'b1)) u_vsync_sync (
    .clk   (clk6m),
    .reset (reset),
    .d_i   (vsync_i),
    .out_o (frame_tick)
  );

  sync_edge #(.EDGE(1'b0)) u_user_sync (
    .clk   (clk6m),
    .reset (reset),
    .d_i   (user_act),
    .out_o (user_sync)
  );

  always_comb begin
    lim = 16'd0;
    case (state_q)
      ST_WAIT_COIN:      lim = COIN_WAIT_W;
      ST_COIN, ST_START: lim = PULSE_LEN_W;
      ST_WAIT_START:     lim = START_WAIT_W;
      ST_PLAY:           lim = PLAY_LEN_W;
      default:           lim = 16'd0;
    endcase
  end

  assign cnt_inc   = sat_inc(cnt_q);
  assign timed_out = frame_tick && (cnt_inc == lim);

  always_comb begin
    hold_d = hold_q;
    if (user_sync) begin
      hold_d = HOLDOFF_W;
    end else if (frame_tick && (hold_q != 16'd0)) begin
      hold_d = hold_q - 16'd1;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (hold_q == 16'd0) state_d = ST_WAIT_COIN;
      ST_WAIT_COIN:  if (timed_out) state_d = ST_COIN;
      ST_COIN:       if (timed_out) state_d = ST_WAIT_START;
      ST_WAIT_START: if (timed_out) state_d = ST_START;
      ST_START:      if (timed_out) state_d = ST_PLAY;
      ST_PLAY:       if (timed_out) state_d = ST_WAIT_COIN;
      default:       state_d = ST_IDLE;
    endcase
    // Abort outranks every timed exit, including one on this very frame_tick.
    if (!enable || user_sync) begin
      state_d = ST_IDLE;
    end

    // ph_q tracks count mod THROW_PERIOD without a divider; count never saturates inside PLAY.
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
      ph_d  = 16'd0;
    end else if (frame_tick) begin
      cnt_d = cnt_inc;
      ph_d  = (ph_q >= THROW_PERIOD_W - 16'd1) ? 16'd0 : ph_q + 16'd1;
    end

    out_d         = OUT_DEFAULT;
    out_d.active  = (state_d != ST_IDLE);
    out_d.coin_n  = (state_d != ST_COIN);
    out_d.start_n = (state_d != ST_START);
    out_d.throw_n = !((state_d == ST_PLAY) && (ph_d < THROW_LEN_W));
  end

  always_ff @(posedge clk6m) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      ph_q    <= 16'd0;
      hold_q  <= 16'd0;
      out_q   <= OUT_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign auto_coin_n  = out_q.coin_n;
  assign auto_start_n = out_q.start_n;
  assign auto_throw_n = out_q.throw_n;
  assign active       = out_q.active;
  assign state_o      = state_q;

endmodule

// File: tb/tb_autoplay_seq.sv
// Bench for autoplay_seq with short timing parameters; one frame is 7 clocks of stimulus.
module tb_autoplay_seq;
  import ff_pkg::*;

  logic       clk6m;
  logic       reset;
  logic       enable;
  logic       vsync_i;
  logic       user_act;
  logic       auto_coin_n;
  logic       auto_start_n;
  logic       auto_throw_n;
  logic       active;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         tick;
    logic [2:0] st;
    logic       coin_n;
    logic       start_n;
    logic       throw_n;
  } vec_t;

  vec_t vecs [20];
  vec_t sb_q [$];

  autoplay_seq #(
    .COIN_WAIT    (2),
    .PULSE_LEN    (2),
    .START_WAIT   (2),
    .THROW_PERIOD (4),
    .THROW_LEN    (1),
    .PLAY_LEN     (8),
    .HOLDOFF      (3)
  ) dut (
    .clk6m        (clk6m),
    .reset        (reset),
    .enable       (enable),
    .vsync_i      (vsync_i),
    .user_act     (user_act),
    .auto_coin_n  (auto_coin_n),
    .auto_start_n (auto_start_n),
    .auto_throw_n (auto_throw_n),
    .active       (active),
    .state_o      (state_o)
  );

  initial begin
    clk6m = 1'b0;
    forever #5 clk6m = ~clk6m;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_coin_n"},  16'(auto_coin_n),  16'd1);
    check({tag, "_start_n"}, 16'(auto_start_n), 16'd1);
    check({tag, "_throw_n"}, 16'(auto_throw_n), 16'd1);
    check({tag, "_active"},  16'(active),       16'd0);
    check({tag, "_state"},   16'(state_o),      16'd0);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    vsync_i  = 1'b0;
    user_act = 1'b0;
    repeat (3) @(negedge clk6m);
    check_idle(tag);
    reset = 1'b0;
  endtask

  // Returns at the negedge inside the cycle where frame_tick is high (3 edges after vsync_i rises).
  task automatic do_frame(input logic with_user);
    repeat (4) @(negedge clk6m);
    vsync_i = 1'b1;
    @(negedge clk6m);
    if (with_user) user_act = 1'b1;
    @(negedge clk6m);
    vsync_i = 1'b0;
    @(negedge clk6m);
  endtask

  initial begin
    logic [2:0] st_tab [20];
    vec_t       exp_v;

    reset    = 1'b1;
    enable   = 1'b0;
    vsync_i  = 1'b0;
    user_act = 1'b0;

    st_tab = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
               3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 3'd1, 3'd2, 3'd2};
    for (int k = 0; k < 20; k++) begin
      vecs[k].tick    = k + 1;
      vecs[k].st      = st_tab[k];
      vecs[k].coin_n  = !(vecs[k].tick inside {3, 4, 19, 20});
      vecs[k].start_n = !(vecs[k].tick inside {7, 8});
      vecs[k].throw_n = !(vecs[k].tick inside {9, 13});
    end

    // Full cycle over 20 frames, sampled in each frame_tick cycle.
    enable = 1'b1;
    do_reset("rst0");
    for (int k = 0; k < 20; k++) begin
      sb_q.push_back(vecs[k]);
      do_frame(1'b0);
      exp_v = sb_q.pop_front();
      check($sformatf("t%0d_state", exp_v.tick),   16'(state_o),      16'(exp_v.st));
      check($sformatf("t%0d_coin_n", exp_v.tick),  16'(auto_coin_n),  16'(exp_v.coin_n));
      check($sformatf("t%0d_start_n", exp_v.tick), 16'(auto_start_n), 16'(exp_v.start_n));
      check($sformatf("t%0d_throw_n", exp_v.tick), 16'(auto_throw_n), 16'(exp_v.throw_n));
    end

    // User activity during COIN, then holdoff of 3 frames.
    do_reset("rst1");
    repeat (3) do_frame(1'b0);
    check("ua_pre_state",  16'(state_o),     16'd2);
    check("ua_pre_coin_n", 16'(auto_coin_n), 16'd0);
    user_act = 1'b1;
    repeat (2) @(negedge clk6m);
    user_act = 1'b0;
    @(negedge clk6m);
    check("ua_abort_coin_n", 16'(auto_coin_n), 16'd1);
    check("ua_abort_state",  16'(state_o),     16'd0);
    check("ua_abort_active", 16'(active),      16'd0);
    for (int f = 0; f < 3; f++) begin
      do_frame(1'b0);
      check($sformatf("ua_hold_tick%0d_state", f + 1), 16'(state_o), 16'd0);
    end
    @(negedge clk6m);
    check("ua_hold_last_state", 16'(state_o), 16'd0);
    @(negedge clk6m);
    check("ua_reenter_state", 16'(state_o), 16'd1);

    // enable dropped while a throw pulse is active.
    do_reset("rst2");
    repeat (8) do_frame(1'b0);
    check("en_pre_state", 16'(state_o), 16'd4);
    @(negedge clk6m);
    check("en_play_state",   16'(state_o),      16'd5);
    check("en_play_throw_n", 16'(auto_throw_n), 16'd0);
    enable = 1'b0;
    @(negedge clk6m);
    check("en_abort_throw_n", 16'(auto_throw_n), 16'd1);
    check("en_abort_state",   16'(state_o),      16'd0);
    check("en_abort_active",  16'(active),       16'd0);
    enable = 1'b1;

    // Reset asserted mid start pulse.
    do_reset("rst3");
    repeat (7) do_frame(1'b0);
    check("rs_pre_state",   16'(state_o),      16'd4);
    check("rs_pre_start_n", 16'(auto_start_n), 16'd0);
    reset = 1'b1;
    @(negedge clk6m);
    check_idle("rs_start");
    reset = 1'b0;

    // User activity coincides with the WAIT_START exit tick.
    do_reset("rst4");
    repeat (5) do_frame(1'b0);
    do_frame(1'b1);
    check("co_tick_state", 16'(state_o), 16'd3);
    user_act = 1'b0;
    @(negedge clk6m);
    check("co_abort_state",   16'(state_o),      16'd0);
    check("co_abort_start_n", 16'(auto_start_n), 16'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk6m);
      check($sformatf("co_after%0d_start_n", c), 16'(auto_start_n), 16'd1);
    end

    // Illegal state code recovers to IDLE.
    do_reset("rst5");
    repeat (3) do_frame(1'b0);
    check("bad_pre_coin_n", 16'(auto_coin_n), 16'd0);
    force dut.state_q = state_t'(3'd7);
    #1;
    check("bad_forced_state", 16'(state_o), 16'd7);
    @(negedge clk6m);
    check("bad_coin_n",  16'(auto_coin_n),  16'd1);
    check("bad_start_n", 16'(auto_start_n), 16'd1);
    check("bad_throw_n", 16'(auto_throw_n), 16'd1);
    check("bad_active",  16'(active),       16'd0);
    release dut.state_q;
    @(negedge clk6m);
    check("bad_recover_state", 16'(state_o), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
